// File: rtl/dct_block_fetch_if.sv
// Link bundle for dct_block_fetch: start/status, MEM_IN read port and the pixel stream.
// master = the fetch engine, slave = its environment (memory, controller, row-DCT).
interface dct_block_fetch_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_sob;
  logic              pix_eob;
  logic              pix_last;

  modport master (
    input  start,
    output busy, done,
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output pix_valid,
    input  pix_ready,
    output pix_data, pix_sob, pix_eob, pix_last
  );

  modport slave (
    output start,
    input  busy, done,
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  pix_valid,
    output pix_ready,
    input  pix_data, pix_sob, pix_eob, pix_last
  );
endinterface

// File: rtl/dct_block_fetch.sv
// Scans the input image as 8x8 tiles (raster block order, row-major inside a block)
// and streams pixels from a 1-cycle synchronous RAM through a 2-entry skid FIFO.
module dct_block_fetch #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int BLK    = 8,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic           clk,
  input  logic           rstn,
  dct_block_fetch_if.master bus
);
  localparam int LB    = $clog2(BLK);
  localparam int LW    = $clog2(IMG_W);
  localparam int BXN   = IMG_W / BLK;
  localparam int BYN   = IMG_H / BLK;
  localparam int BX_W  = (BXN > 1) ? $clog2(BXN) : 1;
  localparam int BY_W  = (BYN > 1) ? $clog2(BYN) : 1;
  localparam int ENT_W = PIX_W + 3;

  localparam logic [LB-1:0]   PIX_MAX = LB'(BLK - 1);
  localparam logic [BX_W-1:0] BX_MAX  = BX_W'(BXN - 1);
  localparam logic [BY_W-1:0] BY_MAX  = BY_W'(BYN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [LB-1:0]     c_q, c_d, r_q, r_d;
  logic [BX_W-1:0]   bx_q, bx_d;
  logic [BY_W-1:0]   by_q, by_d;
  logic              vld_p1_q, vld_p1_d;
  logic              sob_p1_q, sob_p1_d;
  logic              eob_p1_q, eob_p1_d;
  logic              last_p1_q, last_p1_d;
  logic [ENT_W-1:0]  fifo_q [2];
  logic [ENT_W-1:0]  fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic              c_max, r_max, bx_max, by_max;
  logic              tag_sob, tag_eob, tag_last;
  logic [ENT_W-1:0]  head;

  // Row = by*BLK + r and column = bx*BLK + c; with power-of-2 sizes both are concatenations.
  function automatic logic [ADDR_W-1:0] addr_calc(
    input logic [BY_W-1:0] by,
    input logic [LB-1:0]   r,
    input logic [BX_W-1:0] bx,
    input logic [LB-1:0]   c
  );
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = ADDR_W'({by, r});
    col = ADDR_W'({bx, c});
    return (row << LW) | col;
  endfunction

  assign pop    = (cnt_q != 2'd0) && bus.pix_ready;
  // Credit check: entries held plus the read still in flight, less what leaves this cycle.
  assign occ    = {1'b0, cnt_q} + {2'b00, vld_p1_q} - {2'b00, pop};
  assign issue  = (state_q == S_RUN) && (occ < 3'd2);

  assign c_max    = (c_q == PIX_MAX);
  assign r_max    = (r_q == PIX_MAX);
  assign bx_max   = (bx_q == BX_MAX);
  assign by_max   = (by_q == BY_MAX);
  assign tag_sob  = (r_q == '0) && (c_q == '0);
  assign tag_eob  = r_max && c_max;
  assign tag_last = tag_eob && bx_max && by_max;

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    r_d       = r_q;
    bx_d      = bx_q;
    by_d      = by_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    vld_p1_d  = issue;
    sob_p1_d  = tag_sob;
    eob_p1_d  = tag_eob;
    last_p1_d = tag_last;

    if (issue) begin
      c_d = c_q + 1'b1;
      if (c_max) begin
        r_d = r_q + 1'b1;
        if (r_max) begin
          bx_d = bx_max ? '0 : bx_q + 1'b1;
          if (bx_max) begin
            by_d = by_max ? '0 : by_q + 1'b1;
          end
        end
      end
    end

    // Stage p1 -> FIFO: RAM data arrives one cycle after issue, joined with its tags.
    if (vld_p1_q) begin
      fifo_d[wr_ptr_q] = {bus.mem_rdata, sob_p1_q, eob_p1_q, last_p1_q};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, vld_p1_q} - {1'b0, pop};

    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (issue && tag_last) state_d = S_DRAIN;
      // Leave as soon as the final pixel is being handed over this cycle.
      S_DRAIN: if ((cnt_d == 2'd0) && !vld_p1_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      r_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      vld_p1_q  <= 1'b0;
      sob_p1_q  <= 1'b0;
      eob_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      r_q       <= r_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      vld_p1_q  <= vld_p1_d;
      sob_p1_q  <= sob_p1_d;
      eob_p1_q  <= eob_p1_d;
      last_p1_q <= last_p1_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign head          = fifo_q[rd_ptr_q];
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = addr_calc(by_q, r_q, bx_q, c_q);
  assign bus.pix_valid = (cnt_q != 2'd0);
  assign bus.pix_data  = head[ENT_W-1:3];
  assign bus.pix_sob   = head[2] && bus.pix_valid;
  assign bus.pix_eob   = head[1] && bus.pix_valid;
  assign bus.pix_last  = head[0] && bus.pix_valid;
endmodule

// File: tb/tb_dct_block_fetch.sv
// Scoreboard bench for dct_block_fetch: a tile-order reference model fills the expected
// queue at start; a negedge monitor checks reads, pixels, stalls and completion.
module tb_dct_block_fetch;
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int BLK    = 8;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 14;
  localparam int N      = IMG_W * IMG_H;
  localparam int DONE_C = N + 3;

  typedef struct packed {
    logic [PIX_W-1:0] d;
    logic sob;
    logic eob;
    logic last;
  } exp_t;

  logic clk;
  logic rstn;
  dct_block_fetch_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus();

  dct_block_fetch #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BLK(BLK), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.master)
  );

  logic [PIX_W-1:0] mem [N];
  int               exp_addr [N];
  exp_t             sbq [$];

  int   errors = 0;
  int   checks = 0;
  int   issued, popped, done_cnt, scan_cyc, exp_done_cyc;
  bit   scan_active = 0;
  bit   first_vld_seen;
  bit   held_vld;
  logic [PIX_W+2:0] held;
  int   ready_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference order: block index by raster, pixel index row-major within the block.
  task automatic gen_expect();
    int blk, w, bx, by, r, c, a;
    exp_t e;
    sbq.delete();
    for (int i = 0; i < N; i++) begin
      blk = i / (BLK * BLK);
      w   = i % (BLK * BLK);
      bx  = blk % (IMG_W / BLK);
      by  = blk / (IMG_W / BLK);
      r   = w / BLK;
      c   = w % BLK;
      a   = (by * BLK + r) * IMG_W + bx * BLK + c;
      exp_addr[i] = a;
      e.d    = mem[a];
      e.sob  = (w == 0);
      e.eob  = (w == BLK * BLK - 1);
      e.last = (i == N - 1);
      sbq.push_back(e);
    end
  endtask

  // MEM_IN: synchronous RAM, data one cycle after the strobe.
  initial begin
    forever begin
      @(posedge clk);
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = 1'($urandom_range(0, 1));
        default: bus.pix_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  initial begin
    bit   pop_now, exp_en;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (!scan_active) begin
          if (bus.done) chk("spurious_done", 1, 0);
        end else begin
          pop_now = bus.pix_valid && bus.pix_ready;
          exp_en  = (issued < N) && ((issued - popped - int'(pop_now)) < 2);
          chk("rd_en", bus.mem_rd_en, exp_en);
          if (bus.mem_rd_en) begin
            if (issued < N) chk("rd_addr", bus.mem_addr, exp_addr[issued]);
            issued++;
          end
          if (held_vld) begin
            chk("stall_hold", {bus.pix_valid, bus.pix_data, bus.pix_sob, bus.pix_eob, bus.pix_last},
                {1'b1, held});
          end
          if (bus.pix_valid && !first_vld_seen) begin
            first_vld_seen = 1;
            chk("first_valid_cycle", scan_cyc, 3);
          end
          if (pop_now) begin
            if (sbq.size() == 0) begin
              chk("extra_pixel", popped, N);
            end else begin
              e = sbq.pop_front();
              chk("pix_data", bus.pix_data, e.d);
              chk("pix_tags", {bus.pix_sob, bus.pix_eob, bus.pix_last}, {e.sob, e.eob, e.last});
            end
            popped++;
          end
          held_vld = bus.pix_valid && !bus.pix_ready;
          held     = {bus.pix_data, bus.pix_sob, bus.pix_eob, bus.pix_last};
          if (bus.done) begin
            done_cnt++;
            if (exp_done_cyc != 0) chk("done_cycle", scan_cyc, exp_done_cyc);
            chk("done_all_popped", popped, N);
            scan_active = 0;
          end
          scan_cyc++;
        end
      end
    end
  end

  task automatic start_scan(input int done_c, input int mode);
    gen_expect();
    exp_done_cyc   = done_c;
    issued         = 0;
    popped         = 0;
    done_cnt       = 0;
    first_vld_seen = 0;
    held_vld       = 0;
    ready_mode     = mode;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    scan_cyc    = 1;
    scan_active = 1;
  endtask

  task automatic wait_popped(input int target);
    int k;
    k = 0;
    while (popped < target && k < 60000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_pixels_timeout", popped >= target, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (scan_active && k < 60000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_timeout", scan_active, 0);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("busy_after_done", bus.busy, 0);
    chk("pixel_total", popped, N);
    chk("scoreboard_empty", sbq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.pix_valid,
             bus.pix_data, bus.pix_sob, bus.pix_eob, bus.pix_last}, 0);
  endtask

  initial begin
    int k;
    rstn      = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs_init");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Ramp image, ready held high; a stray start at pixel 100 must change nothing.
    for (int a = 0; a < N; a++) mem[a] = PIX_W'(a);
    start_scan(DONE_C, 0);
    wait_popped(100);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("busy_mid_scan", bus.busy, 1);
    wait_done();

    // Random image with random backpressure.
    for (int a = 0; a < N; a++) mem[a] = PIX_W'($urandom);
    start_scan(0, 1);
    wait_done();

    // Long stall after the first valid pixel, then reset mid-scan at pixel 500.
    start_scan(0, 2);
    k = 0;
    while (!first_vld_seen && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("first_valid_timeout", first_vld_seen, 1);
    repeat (20) @(negedge clk);
    chk("stall_reads_outstanding", issued, 2);
    chk("stall_no_pop", popped, 0);
    ready_mode = 0;
    wait_popped(500);
    rstn        = 1'b0;
    scan_active = 0;
    sbq.delete();
    @(negedge clk);
    check_reset_outputs("reset_outputs_midscan");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs_hold");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", bus.busy, 0);

    // Fresh scan after reset must restart at address 0 with sob.
    for (int a = 0; a < N; a++) mem[a] = PIX_W'($urandom);
    start_scan(DONE_C, 0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
